twp_regfile_p: RTL and testbench
================================

Name: twp_regfile_p

Overview:
- Parametrised successor to the two-wire-protocol (TWP) register slave.
- Holds a DEPTH x DW register file reachable from two sides:
  - the TWP serial link on SCL/SDA;
  - the parallel Register Interface Master (RIM) port (cfg_*).
- Beyond the previous generation, it adds:
  - generic address and data widths;
  - a defined same-address write collision rule;
  - frame abort via SCL;
  - a read-data snapshot;
  - busy/error status.

Parameters:
- AW, 8, address width in bits; DEPTH = 2**AW.
- DW, 16, register data width in bits (DW >= 2).
- RST_VAL, 0, reset value loaded into every register.

Ports:
- clk  input  1  sole clock; SDA and SCL are sampled on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- SCL  input  1  frame qualifier; must be high for the whole frame.
- SDA  inout  1  serial data, externally pulled high; slave drives it only during read turnaround/data.
- cfg_req  input  1  RIM request, one-cycle pulse.
- cfg_cmd  input  1  1 = write, 0 = read.
- cfg_addr  input  AW  RIM address.
- cfg_wdata  input  DW  RIM write data.
- cfg_rdy  output  1  one-cycle completion pulse.
- cfg_rdata  output  DW  RIM read data, valid while cfg_rdy = 1.
- twp_busy  output  1  high whenever the FSM is not in IDLE.
- twp_err  output  1  sticky abort/parity error flag; cleared by reset or a RIM write to address 0 with cfg_wdata[DW-1] = 1.

Behaviour:
- Reset values:
  - cfg_rdy = 0, cfg_rdata = 0, twp_busy = 0, twp_err = 0;
  - SDA released (z);
  - FSM in IDLE;
  - all registers = RST_VAL.
- RIM timing: cfg_req sampled at edge N → cfg_rdy = 1 for exactly one cycle after edge N.
  - Read: cfg_rdata = reg[cfg_addr] as it stood before edge N.
  - Write: committed at edge N.
  - Back-to-back requests are accepted every cycle.
- TWP frame: one bit per clk; all multi-bit fields are sent LSB first.
- FSM states and transitions:
  - IDLE: leave on SDA = 0 with SCL = 1 (start bit).
  - CMD: sample 1 bit; 1 → WADDR, 0 → RADDR.
  - WADDR / RADDR: AW cycles shifting the address in.
  - WDATA: DW cycles shifting data in. The register is written on the edge that samples the final bit; then → IDLE.
  - TAR0: 1 cycle, SDA released.
  - TAR1: slave drives 1.
  - TAR2: slave drives 0. reg[addr] is snapshotted into the read shift register on entry to TAR2.
  - RDATA: DW cycles; slave drives snapshot bit i.
  - REND: slave drives 1 for one cycle, releases SDA, → IDLE.
- Collision rule: a TWP commit and a RIM write at the same edge to the same address → the RIM value wins. Different addresses → both commit.
- Snapshot: RIM writes after the snapshot do not alter the serial read data.
- Frame abort: SCL = 0 in any non-IDLE state →
  - next state IDLE;
  - SDA released the next cycle;
  - no pending register write;
  - twp_err set.
- Reset mid-frame: immediate return to IDLE, SDA released, register contents return to RST_VAL.
- Counters: width clog2(max(AW,DW) + 1); no wrap-around beyond field length.

Optional Feature:
- Macro: TWP_PARITY_EN.
- Defined:
  - Write frames carry one extra even-parity bit (over the addr and data fields) after the data, in state WPAR. Commit happens on the WPAR edge, and only if parity is correct; a mismatch drops the write and sets twp_err.
  - Read frames: the slave drives an even-parity bit over the snapshot in state RPAR, between RDATA and REND.
- Undefined: no WPAR/RPAR states; frame lengths as above.

Decomposition:
- Package twp_pkg holds:
  - the FSM state enum;
  - the CMD_WRITE/CMD_READ constants;
  - the TAR drive constants;
  - a parity function.
- One natural sub-module: twp_regfile_mem, the dual-write/dual-read register array implementing the collision priority.
- The FSM and SDA driver stay in the top module.

Test Plan (AW = 8, DW = 16):
- TWP write: addr 0x3C, data 0xA55A. Then RIM read of 0x3C → cfg_rdy one cycle later with cfg_rdata = 0xA55A.
- RIM write: 0x10 ← 0x1234. Then TWP read of 0x10 → SDA sequence z,1,0, then 0x1234 LSB first, then 1, then z; twp_busy low after REND.
- Collision: TWP final data bit and RIM write hit 0x20 at the same edge (TWP 0xFFFF, RIM 0x0001) → reg[0x20] = 0x0001.
- Snapshot: TWP read of 0x05 (0x00F0); RIM write 0x05 ← 0xBEEF during RDATA → serial data still 0x00F0, later RIM read returns 0xBEEF.
- Abort: SCL pulled low at the 5th data bit of a write to 0x7F → reg[0x7F] unchanged, twp_err = 1, FSM back in IDLE; RIM write to address 0 with bit 15 set clears twp_err.
- With TWP_PARITY_EN: write to 0x01 with a wrong parity bit → register unchanged, twp_err = 1. The same frame with correct parity → committed.

Source files
------------

// File: rtl/twp_pkg.sv
// Shared types and constants for the TWP register slave.
// Optional macro TWP_PARITY_EN adds the WPAR/RPAR parity states.
package twp_pkg;

    // FSM states; parity states exist only when TWP_PARITY_EN is defined
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CMD   = 4'd1,
        ST_WADDR = 4'd2,
        ST_RADDR = 4'd3,
        ST_WDATA = 4'd4,
`ifdef TWP_PARITY_EN
        ST_WPAR  = 4'd5,
        ST_RPAR  = 4'd6,
`endif
        ST_TAR0  = 4'd7,
        ST_TAR1  = 4'd8,
        ST_TAR2  = 4'd9,
        ST_RDATA = 4'd10,
        ST_REND  = 4'd11
    } twp_state_e;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    // Levels the slave drives during turnaround and frame end
    localparam logic TAR1_DRV = 1'b1;
    localparam logic TAR2_DRV = 1'b0;
    localparam logic REND_DRV = 1'b1;

    // Even-parity bit: callers zero-extend their field into 64 bits
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/twp_regfile_p_if.sv
// Parallel RIM port plus status outputs of the TWP register slave.
interface twp_regfile_p_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          cfg_req;
    logic          cfg_cmd;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_rdy;
    logic [DW-1:0] cfg_rdata;
    logic          twp_busy;
    logic          twp_err;

    modport master (
        output cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
        input  cfg_rdy, cfg_rdata, twp_busy, twp_err
    );

    modport slave (
        input  cfg_req, cfg_cmd, cfg_addr, cfg_wdata,
        output cfg_rdy, cfg_rdata, twp_busy, twp_err
    );
endinterface

// File: rtl/twp_regfile_mem.sv
// DEPTH x DW register array with two write ports and two combinational
// read ports. Port B (RIM) wins over port A (TWP) on a same-address write.
module twp_regfile_mem #(
    parameter int unsigned   AW      = 8,
    parameter int unsigned   DW      = 16,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata,
    input  logic [AW-1:0] i_ra_addr,
    output logic [DW-1:0] o_ra_data_c,
    input  logic [AW-1:0] i_rb_addr,
    output logic [DW-1:0] o_rb_data_c
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic          w_a_commit;

    assign w_a_commit  = i_a_we && !(i_b_we && (i_b_addr == i_a_addr));
    assign o_ra_data_c = r_mem[i_ra_addr];
    assign o_rb_data_c = r_mem[i_rb_addr];

    // Array update: whole file returns to RST_VAL on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= RST_VAL;
        end else begin
            if (w_a_commit) r_mem[i_a_addr] <= i_a_wdata;
            if (i_b_we)     r_mem[i_b_addr] <= i_b_wdata;
        end
    end
endmodule

// File: rtl/twp_regfile_p.sv
// TWP serial register slave with a parallel RIM port.
// Optional macro TWP_PARITY_EN: even parity on write and read frames.
module twp_regfile_p
    import twp_pkg::*;
#(
    parameter int unsigned   AW      = 8,
    parameter int unsigned   DW      = 16,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          SCL,
    inout  wire           SDA,
    twp_regfile_p_if.slave cfg
);
    localparam int unsigned MAXW = (AW > DW) ? AW : DW;
    localparam int unsigned CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

    twp_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_shift;
    logic          r_sda_oe, r_sda_o, w_sda_oe_nxt, w_sda_o_nxt;
    logic          r_busy, r_err, r_rdy;
    logic [DW-1:0] r_rdata;
    logic          w_sda_in, w_twp_we, w_par_err, w_abort;
    logic          w_rim_we, w_err_clr;
    logic [DW-1:0] w_twp_wdata, w_mem_twp_rd, w_mem_rim_rd;
`ifdef TWP_PARITY_EN
    logic          r_rpar;
`endif

    assign w_sda_in = SDA;
    assign SDA      = r_sda_oe ? r_sda_o : 1'bz;

    assign w_rim_we  = cfg.cfg_req && (cfg.cfg_cmd == CMD_WRITE);
    assign w_err_clr = w_rim_we && (cfg.cfg_addr == '0) && cfg.cfg_wdata[DW-1];

`ifdef TWP_PARITY_EN
    assign w_twp_wdata = r_shift;
`else
    // Final data bit is committed on the same edge that samples it
    assign w_twp_wdata = {w_sda_in, r_shift[DW-1:1]};
`endif

    twp_regfile_mem #(.AW(AW), .DW(DW), .RST_VAL(RST_VAL)) u_mem (
        .clk        (clk),
        .rst        (reset),
        .i_a_we     (w_twp_we),
        .i_a_addr   (r_addr),
        .i_a_wdata  (w_twp_wdata),
        .i_b_we     (w_rim_we),
        .i_b_addr   (cfg.cfg_addr),
        .i_b_wdata  (cfg.cfg_wdata),
        .i_ra_addr  (r_addr),
        .o_ra_data_c(w_mem_twp_rd),
        .i_rb_addr  (cfg.cfg_addr),
        .o_rb_data_c(w_mem_rim_rd)
    );

    // FSM state and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, write strobe, abort detection and SDA drive for next state
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_twp_we     = 1'b0;
        w_par_err    = 1'b0;
        w_abort      = 1'b0;
        w_sda_oe_nxt = 1'b0;
        w_sda_o_nxt  = 1'b1;
        case (r_state)
            ST_IDLE:  if (SCL && !w_sda_in) w_state_nxt = ST_CMD;
            ST_CMD: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (w_sda_in == CMD_READ) ? ST_RADDR : ST_WADDR;
            end
            ST_WADDR, ST_RADDR: begin
                if (r_cnt == ADDR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_state == ST_WADDR) ? ST_WDATA : ST_TAR0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WDATA: begin
                if (r_cnt == DATA_LAST) begin
                    w_cnt_nxt   = '0;
`ifdef TWP_PARITY_EN
                    w_state_nxt = ST_WPAR;
`else
                    w_state_nxt = ST_IDLE;
                    w_twp_we    = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef TWP_PARITY_EN
            ST_WPAR: begin
                w_state_nxt = ST_IDLE;
                if (w_sda_in == even_par(64'({r_addr, r_shift}))) w_twp_we  = 1'b1;
                else                                              w_par_err = 1'b1;
            end
            ST_RPAR:  w_state_nxt = ST_REND;
`endif
            ST_TAR0:  w_state_nxt = ST_TAR1;
            ST_TAR1:  w_state_nxt = ST_TAR2;
            ST_TAR2: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                if (r_cnt == DATA_LAST) begin
                    w_cnt_nxt = '0;
`ifdef TWP_PARITY_EN
                    w_state_nxt = ST_RPAR;
`else
                    w_state_nxt = ST_REND;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_REND:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // SCL low mid-frame abandons the frame, including a pending commit
        if ((r_state != ST_IDLE) && !SCL) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_twp_we    = 1'b0;
            w_par_err   = 1'b0;
            w_abort     = 1'b1;
        end

        case (w_state_nxt)
            ST_TAR1:  begin w_sda_oe_nxt = 1'b1; w_sda_o_nxt = TAR1_DRV;   end
            ST_TAR2:  begin w_sda_oe_nxt = 1'b1; w_sda_o_nxt = TAR2_DRV;   end
            ST_RDATA: begin w_sda_oe_nxt = 1'b1; w_sda_o_nxt = r_shift[0]; end
`ifdef TWP_PARITY_EN
            ST_RPAR:  begin w_sda_oe_nxt = 1'b1; w_sda_o_nxt = r_rpar;     end
`endif
            ST_REND:  begin w_sda_oe_nxt = 1'b1; w_sda_o_nxt = REND_DRV;   end
            default:  ;
        endcase
    end

    // Serial shift paths: address/data in, snapshot out (LSB first)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_shift <= '0;
`ifdef TWP_PARITY_EN
            r_rpar  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_WADDR, ST_RADDR: r_addr  <= {w_sda_in, r_addr[AW-1:1]};
                ST_WDATA:           r_shift <= {w_sda_in, r_shift[DW-1:1]};
                default:            ;
            endcase
            if (w_state_nxt == ST_TAR2) begin
                r_shift <= w_mem_twp_rd;
`ifdef TWP_PARITY_EN
                r_rpar  <= even_par(64'(w_mem_twp_rd));
`endif
            end else if (w_state_nxt == ST_RDATA) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    // Registered outputs: SDA driver, status and RIM completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sda_oe <= 1'b0;
            r_sda_o  <= 1'b1;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_rdy    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_sda_oe <= w_sda_oe_nxt;
            r_sda_o  <= w_sda_o_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            // A fresh error on the same edge as a clear keeps the flag set
            if (w_abort || w_par_err) r_err <= 1'b1;
            else if (w_err_clr)       r_err <= 1'b0;
            r_rdy <= cfg.cfg_req;
            if (cfg.cfg_req && (cfg.cfg_cmd != CMD_WRITE)) r_rdata <= w_mem_rim_rd;
        end
    end

    assign cfg.cfg_rdy   = r_rdy;
    assign cfg.cfg_rdata = r_rdata;
    assign cfg.twp_busy  = r_busy;
    assign cfg.twp_err   = r_err;
endmodule

// File: tb/tb_twp_regfile_p.sv
// Scoreboard bench for twp_regfile_p: drivers push expectations, monitors
// on the RIM completion pulse and on serial read frames pop and compare.
module tb_twp_regfile_p;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef TWP_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl = 1'b1;
    logic tb_sda_en = 1'b0;
    logic tb_sda_o = 1'b1;
    wire  sda;

    pullup (sda);
    assign sda = tb_sda_en ? tb_sda_o : 1'bz;

    twp_regfile_p_if #(.AW(AW), .DW(DW)) cfg_if ();

    twp_regfile_p #(.AW(AW), .DW(DW), .RST_VAL(16'h0000)) dut (
        .clk  (clk),
        .reset(reset),
        .SCL  (scl),
        .SDA  (sda),
        .cfg  (cfg_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents and sticky error flag
    logic [15:0] ref_mem [256];
    bit          ref_err;

    typedef struct {
        bit          rd;
        logic [7:0]  addr;
        logic [15:0] data;
        int unsigned cyc;
    } rim_exp_t;

    rim_exp_t    q_rim[$];
    logic [15:0] q_ser[$];
    bit          ser_go = 1'b0;
    rim_exp_t    mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RIM request; expectation taken from the model before this edge
    task automatic rim(input bit wr, input logic [7:0] a, input logic [15:0] d);
        rim_exp_t e;
        e.rd = !wr; e.addr = a; e.data = ref_mem[a]; e.cyc = cyc;
        q_rim.push_back(e);
        if (wr) begin
            ref_mem[a] = d;
            if (a == 8'h00 && d[15]) ref_err = 1'b0;
        end
        cfg_if.cfg_req   = 1'b1;
        cfg_if.cfg_cmd   = wr;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        @(posedge clk); #1;
        cfg_if.cfg_req = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        tb_sda_en = 1'b1;
        tb_sda_o  = b;
        @(posedge clk); #1;
    endtask

    // Serial write; abort_at >= 0 drops SCL on that data bit
    task automatic twp_write(input logic [7:0] a, input logic [15:0] d,
                             input int abort_at, input bit par_flip, input bit upd);
        drive_bit(1'b0);
        drive_bit(1'b1);
        for (int i = 0; i < AW; i++) drive_bit(a[i]);
        for (int i = 0; i < DW; i++) begin
            if (i == abort_at) scl = 1'b0;
            drive_bit(d[i]);
            if (i == abort_at) begin
                tb_sda_en = 1'b0;
                scl = 1'b1;
                ref_err = 1'b1;
                return;
            end
        end
`ifdef TWP_PARITY_EN
        drive_bit((^{a, d}) ^ par_flip);
        if (par_flip) ref_err = 1'b1;
        else if (upd) ref_mem[a] = d;
`else
        if (upd && !par_flip) ref_mem[a] = d;
`endif
        tb_sda_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic twp_read(input logic [7:0] a);
        drive_bit(1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < AW; i++) drive_bit(a[i]);
        tb_sda_en = 1'b0;
        q_ser.push_back(ref_mem[a]);
        ser_go = 1'b1;
        repeat (DW + 5 + PB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // RIM monitor: every completion pulse consumes one expectation
    always @(negedge clk) begin
        if (!reset && cfg_if.cfg_rdy) begin
            if (q_rim.size() == 0) begin
                checks++; errors++;
                $display("FAIL rim_rdy: got rdy=1 expected 0 (no request pending)");
            end else begin
                mon_e = q_rim.pop_front();
                check("rim_latency", cyc, mon_e.cyc + 1);
                if (mon_e.rd) check("rim_rdata", 32'(cfg_if.cfg_rdata), 32'(mon_e.data));
            end
        end
    end

    // Serial monitor: samples a read frame from TAR0 onward
    initial begin
        logic [15:0] got, exp;
        logic [2:0]  tar;
        logic        pbit, endb, rel;
        forever begin
            wait (ser_go);
            ser_go = 1'b0;
            pbit = 1'b0;
            for (int i = 0; i < 3; i++) begin @(negedge clk); tar[i] = sda; end
            for (int i = 0; i < DW; i++) begin @(negedge clk); got[i] = sda; end
            if (PB != 0) begin @(negedge clk); pbit = sda; end
            @(negedge clk); endb = sda;
            @(negedge clk); rel = sda;
            if (q_ser.size() == 0) begin
                checks++; errors++;
                $display("FAIL ser_frame: got data %0h expected no frame", got);
            end else begin
                exp = q_ser.pop_front();
                check("ser_turnaround", 32'(tar), 32'h3);
                check("ser_data", 32'(got), 32'(exp));
                if (PB != 0) check("ser_parity", 32'(pbit), 32'(^exp));
                check("ser_end_release", 32'({endb, rel}), 32'h3);
                check("ser_busy_after", 32'(cfg_if.twp_busy), 32'h0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a, a2;
        logic [15:0] d;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_err = 1'b0;
        cfg_if.cfg_req = 1'b0; cfg_if.cfg_cmd = 1'b0;
        cfg_if.cfg_addr = '0; cfg_if.cfg_wdata = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_rdy",   32'(cfg_if.cfg_rdy),   32'h0);
        check("rst_rdata", 32'(cfg_if.cfg_rdata), 32'h0);
        check("rst_busy",  32'(cfg_if.twp_busy),  32'h0);
        check("rst_err",   32'(cfg_if.twp_err),   32'h0);
        check("rst_sda",   32'(sda),              32'h1);
        idle(1);

        // Serial write then parallel read-back
        twp_write(8'h3C, 16'hA55A, -1, 1'b0, 1'b1);
        check("wr_busy", 32'(cfg_if.twp_busy), 32'h0);
        rim(1'b0, 8'h3C, 16'h0);
        idle(2);

        // Parallel write then serial read
        rim(1'b1, 8'h10, 16'h1234);
        twp_read(8'h10);

        // Same-address collision: RIM value wins, TWP data discarded
        fork
            twp_write(8'h20, 16'hFFFF, -1, 1'b0, 1'b0);
            begin
                repeat (AW + DW + 1 + PB) begin @(posedge clk); #1; end
                rim(1'b1, 8'h20, 16'h0001);
            end
        join
        rim(1'b0, 8'h20, 16'h0);

        // Different-address collision: both writes land
        fork
            twp_write(8'h21, 16'hC3C3, -1, 1'b0, 1'b1);
            begin
                repeat (AW + DW + 1 + PB) begin @(posedge clk); #1; end
                rim(1'b1, 8'h22, 16'h7E7E);
            end
        join
        rim(1'b0, 8'h21, 16'h0);
        rim(1'b0, 8'h22, 16'h0);

        // Snapshot: RIM write during RDATA must not disturb the serial word
        rim(1'b1, 8'h05, 16'h00F0);
        fork
            twp_read(8'h05);
            begin
                repeat (AW + 7) begin @(posedge clk); #1; end
                rim(1'b1, 8'h05, 16'hBEEF);
            end
        join
        rim(1'b0, 8'h05, 16'h0);

        // Abort on the fifth data bit
        rim(1'b1, 8'h7F, 16'h1357);
        twp_write(8'h7F, 16'hFFFF, 4, 1'b0, 1'b1);
        check("abort_busy", 32'(cfg_if.twp_busy), 32'h0);
        check("abort_err",  32'(cfg_if.twp_err),  32'(ref_err));
        check("abort_sda",  32'(sda),             32'h1);
        rim(1'b0, 8'h7F, 16'h0);
        rim(1'b1, 8'h00, 16'h8000);
        check("err_clear", 32'(cfg_if.twp_err), 32'(ref_err));

`ifdef TWP_PARITY_EN
        twp_write(8'h01, 16'h5A5B, -1, 1'b1, 1'b1);
        check("par_bad_err", 32'(cfg_if.twp_err), 32'(ref_err));
        rim(1'b0, 8'h01, 16'h0);
        rim(1'b1, 8'h00, 16'h8000);
        twp_write(8'h01, 16'h5A5B, -1, 1'b0, 1'b1);
        check("par_good_err", 32'(cfg_if.twp_err), 32'(ref_err));
        rim(1'b0, 8'h01, 16'h0);
`endif

        // Randomized mix over a small address window
        for (int n = 0; n < 40; n++) begin
            a  = 8'h40 | 8'($urandom_range(0, 7));
            a2 = 8'h40 | 8'($urandom_range(0, 7));
            d  = 16'($urandom);
            case ($urandom_range(0, 4))
                0: rim(1'b1, a, d);
                1: rim(1'b0, a, 16'h0);
                2: twp_write(a, d, -1, 1'b0, 1'b1);
                3: twp_read(a);
                default: begin
                    rim(1'b1, a, d);
                    rim(1'b0, a, 16'h0);
                    rim(1'b1, a2, ~d);
                    rim(1'b0, a2, 16'h0);
                end
            endcase
        end
        idle(3);

        // Reset in the middle of a write frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(cfg_if.twp_busy), 32'h0);
        check("midrst_err",  32'(cfg_if.twp_err),  32'h0);
        tb_sda_en = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        rim(1'b0, 8'h3C, 16'h0);
        rim(1'b0, 8'h10, 16'h0);
        idle(4);

        check("rim_drained", 32'(q_rim.size()), 32'h0);
        check("ser_drained", 32'(q_ser.size()), 32'h0);
        check("final_err",   32'(cfg_if.twp_err),  32'(ref_err));
        check("final_busy",  32'(cfg_if.twp_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
